// File: rtl/mvu_act_feeder.sv
// mvu_act_feeder: buffers one SF-chunk activation vector and replays it NF times with weight addressing.
// Defining MVU_FEEDER_STALL_CNT_EN adds a saturating stall_cnt output.
module mvu_act_feeder #(
    parameter int SIMD    = 2,
    parameter int PE      = 2,
    parameter int TI      = 1,
    parameter int MatrixW = 4,
    parameter int MatrixH = 4,
    localparam int SF = MatrixW / SIMD,
    localparam int NF = MatrixH / PE,
    localparam int W  = TI * SIMD,
    localparam int WA = (SF * NF > 1) ? $clog2(SF * NF) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_v,
    input  logic [W-1:0]  in_act,
    output logic          in_rdy,
    output logic          out_v,
    output logic [W-1:0]  out_act,
    output logic [WA-1:0] out_wgt_addr,
    output logic          out_sf_last,
    output logic          out_nf_last,
    input  logic          out_rdy
`ifdef MVU_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    localparam int SW = SF > 1 ? $clog2(SF) : 1;
    localparam int NW = NF > 1 ? $clog2(NF) : 1;
    localparam logic [SW-1:0] SF_MAX = SW'(SF - 1);
    localparam logic [NW-1:0] NF_MAX = NW'(NF - 1);

    typedef enum logic {FILL, REPLAY} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sf_q, sf_d;
    logic [NW-1:0]   nf_q, nf_d;
    logic            out_v_q, out_v_d;
    logic [W-1:0]    act_q, act_d;
    logic [WA-1:0]   addr_q, addr_d;
    logic            sl_q, sl_d, nl_q, nl_d;
    logic [W-1:0]    mem_q [SF];
    logic            ld, load;

    assign ld           = !out_v_q || out_rdy;
    assign in_rdy       = state_q == FILL && ld;
    assign load         = ld && (state_q == REPLAY || in_v);
    assign out_v        = out_v_q;
    assign out_act      = act_q;
    assign out_wgt_addr = addr_q;
    assign out_sf_last  = sl_q;
    assign out_nf_last  = nl_q;

    always_comb begin
        state_d = state_q;
        sf_d    = sf_q;
        nf_d    = nf_q;
        out_v_d = ld ? load : out_v_q;
        act_d   = act_q;
        addr_d  = addr_q;
        sl_d    = sl_q;
        nl_d    = nl_q;
        if (load) begin
            act_d  = state_q == FILL ? in_act : mem_q[sf_q];
            addr_d = WA'(32'(nf_q) * SF + 32'(sf_q));
            sl_d   = sf_q == SF_MAX;
            nl_d   = nf_q == NF_MAX;
            sf_d   = sf_q == SF_MAX ? '0 : sf_q + SW'(1);
            if (sf_q == SF_MAX) begin
                nf_d    = nf_q == NF_MAX ? '0 : nf_q + NW'(1);
                state_d = nf_q == NF_MAX ? FILL : REPLAY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            sf_q    <= '0;
            nf_q    <= '0;
            out_v_q <= 1'b0;
            act_q   <= '0;
            addr_q  <= '0;
            sl_q    <= 1'b0;
            nl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sf_q    <= sf_d;
            nf_q    <= nf_d;
            out_v_q <= out_v_d;
            act_q   <= act_d;
            addr_q  <= addr_d;
            sl_q    <= sl_d;
            nl_q    <= nl_d;
        end
    end

    // Vector buffer is captured only during FILL and needs no reset.
    always_ff @(posedge clk) begin
        if (in_rdy && in_v) mem_q[sf_q] <= in_act;
    end

`ifdef MVU_FEEDER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else if (out_v_q && !out_rdy && stall_q != '1) stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mvu_act_feeder.sv
// tb_mvu_act_feeder: checks an NF=2 and an NF=1 feeder against an expected-output queue model.
// Stall counter checks are active when MVU_FEEDER_STALL_CNT_EN is defined.
module tb_mvu_act_feeder;
    localparam int W = 8;
    localparam int SFP[2] = '{2, 2};
    localparam int NFP[2] = '{2, 1};

    typedef struct packed {
        logic [W-1:0] act;
        logic [31:0]  addr;
        logic         sl;
        logic         nl;
    } ent_t;

    logic clk = 1'b0, rst_n = 1'b0, in_v = 1'b0, out_rdy = 1'b0;
    logic [W-1:0] in_act = '0;
    logic rdy [2], v [2], sl [2], nl [2];
    logic [W-1:0] act [2];
    logic [1:0] a0;
    logic [0:0] a1;
`ifdef MVU_FEEDER_STALL_CNT_EN
    logic [31:0] sc [2];
`endif

    ent_t q [2][$];
    logic shown [2];
    int kin [2];
    logic [W-1:0] vec [2][2];
    int stall_m [2];
    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    mvu_act_feeder #(.SIMD(2), .PE(2), .TI(4), .MatrixW(4), .MatrixH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_act(in_act), .in_rdy(rdy[0]),
        .out_v(v[0]), .out_act(act[0]), .out_wgt_addr(a0), .out_sf_last(sl[0]),
        .out_nf_last(nl[0]), .out_rdy(out_rdy)
`ifdef MVU_FEEDER_STALL_CNT_EN
        , .stall_cnt(sc[0])
`endif
    );

    mvu_act_feeder #(.SIMD(2), .PE(2), .TI(4), .MatrixW(4), .MatrixH(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_act(in_act), .in_rdy(rdy[1]),
        .out_v(v[1]), .out_act(act[1]), .out_wgt_addr(a1), .out_sf_last(sl[1]),
        .out_nf_last(nl[1]), .out_rdy(out_rdy)
`ifdef MVU_FEEDER_STALL_CNT_EN
        , .stall_cnt(sc[1])
`endif
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s[dut%0d] observed=%0h expected=%0h @%0t", tag, d, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            q[d].delete();
            shown[d]   = 1'b0;
            kin[d]     = 0;
            stall_m[d] = 0;
        end
    endtask

    task automatic chk_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_v", d, 32'(v[d]), 0);
            chk("rst_out_act", d, 32'(act[d]), 0);
            chk("rst_addr", d, d ? 32'(a1) : 32'(a0), 0);
            chk("rst_sf_last", d, 32'(sl[d]), 0);
            chk("rst_nf_last", d, 32'(nl[d]), 0);
            chk("rst_in_rdy", d, 32'(rdy[d]), 1);
`ifdef MVU_FEEDER_STALL_CNT_EN
            chk("rst_stall", d, sc[d], 0);
`endif
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic ld;
            int pend;
            ld   = !shown[d] || out_rdy;
            pend = q[d].size() - (shown[d] ? 1 : 0);
            chk("in_rdy", d, 32'(rdy[d]), 32'(ld && pend == 0));
            chk("out_v", d, 32'(v[d]), 32'(shown[d]));
            if (shown[d]) begin
                chk("out_act", d, 32'(act[d]), 32'(q[d][0].act));
                chk("addr", d, d ? 32'(a1) : 32'(a0), q[d][0].addr);
                chk("sf_last", d, 32'(sl[d]), 32'(q[d][0].sl));
                chk("nf_last", d, 32'(nl[d]), 32'(q[d][0].nl));
            end
`ifdef MVU_FEEDER_STALL_CNT_EN
            chk("stall_cnt", d, sc[d], 32'(stall_m[d]));
`endif
        end
    endtask

    // Each accepted chunk shows up once now; the last chunk of a vector also schedules every replay fold.
    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            logic ld, acc;
            int pend;
            ent_t e;
            ld   = !shown[d] || out_rdy;
            pend = q[d].size() - (shown[d] ? 1 : 0);
            acc  = in_v && ld && pend == 0;
            if (shown[d] && !out_rdy) stall_m[d]++;
            if (shown[d] && out_rdy) begin
                void'(q[d].pop_front());
                shown[d] = 1'b0;
            end
            if (acc) begin
                vec[d][kin[d]] = in_act;
                e.act  = in_act;
                e.addr = 32'(kin[d]);
                e.sl   = kin[d] == SFP[d] - 1;
                e.nl   = NFP[d] == 1;
                q[d].push_back(e);
                if (kin[d] == SFP[d] - 1)
                    for (int n = 1; n < NFP[d]; n++)
                        for (int s = 0; s < SFP[d]; s++) begin
                            e.act  = vec[d][s];
                            e.addr = 32'(n * SFP[d] + s);
                            e.sl   = s == SFP[d] - 1;
                            e.nl   = n == NFP[d] - 1;
                            q[d].push_back(e);
                        end
                kin[d] = (kin[d] + 1) % SFP[d];
            end
            if (ld) shown[d] = q[d].size() > 0;
        end
    endtask

    task automatic step(input logic iv, input logic [W-1:0] a, input logic r);
        in_v    = iv;
        in_act  = a;
        out_rdy = r;
        #2;
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #2 chk_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        // fill two chunks, then replay
        step(1'b1, 8'hA1, 1'b1);
        step(1'b1, 8'hB2, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        // back-pressure while addr 1 is on the output
        step(1'b1, 8'hC3, 1'b1);
        step(1'b1, 8'hD4, 1'b1);
        repeat (5) step(1'b1, 8'h55, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        // input bubble during FILL
        step(1'b1, 8'hE5, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hF6, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        // back-to-back vectors
        repeat (8) step(1'b1, W'($urandom), 1'b1);
        // seven stalled cycles with a valid output
        step(1'b1, 8'h77, 1'b1);
        repeat (7) step(1'b0, 8'h00, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        // reset in the middle of a vector
        step(1'b1, 8'h99, 1'b1);
        rst_n = 1'b0;
        #1 chk_reset();
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 8'h3C, 1'b1);
        step(1'b1, 8'h4D, 1'b1);
        repeat (300) step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0);
        repeat (6) step(1'b0, 8'h00, 1'b1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
